minimax_dmem: RTL and testbench

// - Data-memory responder for the minimax core's load/store port; the target end of addr/wdata/wmask/rreq/rack.
// - Holds a word-organised SRAM with byte-lane writes; answers one-cycle rreq pulses with a one-cycle rack after a set wait.
// - Sits beside the core in the SoC top level; instruction fetch is not served here.

---
 rtl/minimax_dmem_pkg.sv | 15 +
 rtl/minimax_dmem_ram.sv | 33 +++
 rtl/minimax_dmem.sv | 168 ++++++++++++++++
 tb/tb_minimax_dmem.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/minimax_dmem_pkg.sv
// Shared types and constants for the minimax data-memory responder.
// Read FSM states, MMIO register offsets and the byte-lane count.
package minimax_dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [31:0] MMIO_OFF_OUT = 32'd0;
   localparam logic [31:0] MMIO_OFF_IN  = 32'd4;
   localparam int unsigned LANES        = 4;

endpackage

// File: rtl/minimax_dmem_ram.sv
// Word-organised SRAM with per-byte write enables and a registered read port.
// Write and read use separate indices so stores are never blocked by a pending load.
module minimax_dmem_ram
   import minimax_dmem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 i_clk,
   input  logic [ADDR_BITS-1:0] i_widx,
   input  logic [LANES-1:0]     i_we,
   input  logic [31:0]          i_wdata,
   input  logic                 i_re,
   input  logic [ADDR_BITS-1:0] i_ridx,
   output logic [31:0]          o_rdata
);

   logic [31:0] r_mem [2**ADDR_BITS];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (i_we[i]) begin
            r_mem[i_widx][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
      if (i_re) begin
         r_rdata <= r_mem[i_ridx];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/minimax_dmem.sv
// Data-memory responder for the minimax load/store port: SRAM window, read FSM, rdata gating.
// Optional MMIO output/input register pair enabled by defining MINIMAX_DMEM_MMIO_EN.
module minimax_dmem
   import minimax_dmem_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = 10,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] MMIO_ADDR    = 32'h0000_F000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wmask,
   input  logic        i_rreq,
   output logic [31:0] o_rdata,
`ifdef MINIMAX_DMEM_MMIO_EN
   output logic [31:0] o_gpio_out,
   input  logic [31:0] i_gpio_in,
`endif
   output logic        o_rack
);

   localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

   // Word-granular offset; byte bits of the address play no part in decode.
   logic [29:0]          w_off;
   logic                 w_hit;
   logic                 w_sram_hit;
   logic [ADDR_BITS-1:0] w_idx;
   logic                 w_unused;

   assign w_off    = i_addr[31:2] - BASE_ADDR[31:2];
   assign w_hit    = (w_off[29:ADDR_BITS] == '0);
   assign w_idx    = w_off[ADDR_BITS-1:0];
   assign w_unused = ^i_addr[1:0];

`ifdef MINIMAX_DMEM_MMIO_EN
   localparam logic [31:0] MMIO_OUT_A = MMIO_ADDR + MMIO_OFF_OUT;
   localparam logic [31:0] MMIO_IN_A  = MMIO_ADDR + MMIO_OFF_IN;

   logic        w_mmio_out;
   logic        w_mmio_in;
   logic        r_sel_out;
   logic        r_sel_in;
   logic [31:0] r_gpio_out;

   assign w_mmio_out = (i_addr[31:2] == MMIO_OUT_A[31:2]);
   assign w_mmio_in  = (i_addr[31:2] == MMIO_IN_A[31:2]);
   assign w_sram_hit = w_hit && !w_mmio_out && !w_mmio_in;
   assign o_gpio_out = r_gpio_out;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_gpio_out <= '0;
      end else if (w_mmio_out) begin
         for (int i = 0; i < LANES; i++) begin
            if (i_wmask[i]) begin
               r_gpio_out[8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
   end
`else
   assign w_sram_hit = w_hit;
`endif

   state_t               r_state;
   state_t               w_state_d;
   logic [3:0]           r_cnt;
   logic [3:0]           w_cnt_d;
   logic [ADDR_BITS-1:0] r_idx;
   logic                 r_hit;
   logic                 w_accept;
   logic                 w_ram_re;
   logic [31:0]          w_ram_rdata;

   assign w_accept = i_rreq && (r_state == IDLE || r_state == ACK);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_hit   <= 1'b0;
`ifdef MINIMAX_DMEM_MMIO_EN
         r_sel_out <= 1'b0;
         r_sel_in  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_accept) begin
            r_idx <= w_idx;
            r_hit <= w_sram_hit;
`ifdef MINIMAX_DMEM_MMIO_EN
            r_sel_out <= w_mmio_out;
            r_sel_in  <= w_mmio_in;
`endif
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_ram_re  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_rreq) begin
               w_state_d = WAIT;
               w_cnt_d   = LAT_M1;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_d = ACK;
               w_ram_re  = 1'b1;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         ACK: begin
            if (i_rreq) begin
               w_state_d = WAIT;
               w_cnt_d   = LAT_M1;
            end else begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   minimax_dmem_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .i_clk   (i_clk),
      .i_widx  (w_idx),
      .i_we    (i_wmask & {LANES{w_sram_hit}}),
      .i_wdata (i_wdata),
      .i_re    (w_ram_re),
      .i_ridx  (r_idx),
      .o_rdata (w_ram_rdata)
   );

   assign o_rack = (r_state == ACK);

   // Misses fall through to zero so the core still gets an ack.
   always_comb begin
      o_rdata = '0;
      if (o_rack) begin
         if (r_hit) begin
            o_rdata = w_ram_rdata;
         end
`ifdef MINIMAX_DMEM_MMIO_EN
         if (r_sel_out) begin
            o_rdata = r_gpio_out;
         end
         if (r_sel_in) begin
            o_rdata = i_gpio_in;
         end
`endif
      end
   end

endmodule

// File: tb/tb_minimax_dmem.sv
// Directed self-checking bench: two responders (read latency 1 and 3) share one stimulus bus.
// Exercises MMIO as well when MINIMAX_DMEM_MMIO_EN is defined.
module tb_minimax_dmem;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] MMIO = 32'h0000_F000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        rreq;
   logic [31:0] rdata1;
   logic [31:0] rdata3;
   logic        rack1;
   logic        rack3;
`ifdef MINIMAX_DMEM_MMIO_EN
   logic [31:0] gpio_in;
   logic [31:0] gpio_out1;
   logic [31:0] gpio_out3;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int step  = 0;

   always #5 clk = ~clk;

   minimax_dmem #(
      .READ_LATENCY (1)
   ) u_dut1 (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .i_wmask    (wmask),
      .i_rreq     (rreq),
      .o_rdata    (rdata1),
`ifdef MINIMAX_DMEM_MMIO_EN
      .o_gpio_out (gpio_out1),
      .i_gpio_in  (gpio_in),
`endif
      .o_rack     (rack1)
   );

   minimax_dmem #(
      .READ_LATENCY (3)
   ) u_dut3 (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .i_wmask    (wmask),
      .i_rreq     (rreq),
      .o_rdata    (rdata3),
`ifdef MINIMAX_DMEM_MMIO_EN
      .o_gpio_out (gpio_out3),
      .i_gpio_in  (gpio_in),
`endif
      .o_rack     (rack3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the edge, check both DUTs, then drop the pulse inputs.
   task automatic cyc(input logic er1, input logic [31:0] ed1,
                      input logic er3, input logic [31:0] ed3, input string tag);
      @(posedge clk);
      #1;
      step++;
      chk($sformatf("%s#%0d rack1", tag, step), {31'd0, rack1}, {31'd0, er1});
      chk($sformatf("%s#%0d rdata1", tag, step), rdata1, ed1);
      chk($sformatf("%s#%0d rack3", tag, step), {31'd0, rack3}, {31'd0, er3});
      chk($sformatf("%s#%0d rdata3", tag, step), rdata3, ed3);
      rreq  = 1'b0;
      wmask = 4'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                     input string tag);
      addr  = a;
      wmask = m;
      wdata = d;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, tag);
   endtask

   task automatic rd(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                     input logic [31:0] exp1, input logic [31:0] exp3, input string tag);
      addr  = a;
      rreq  = 1'b1;
      wmask = m;
      wdata = d;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, tag);
      cyc(1'b1, exp1,  1'b0, 32'h0, tag);
      cyc(1'b0, 32'h0, 1'b0, 32'h0, tag);
      cyc(1'b0, 32'h0, 1'b1, exp3,  tag);
      cyc(1'b0, 32'h0, 1'b0, 32'h0, tag);
   endtask

   initial begin
      reset = 1'b1;
      addr  = '0;
      wdata = '0;
      wmask = 4'h0;
      rreq  = 1'b0;
`ifdef MINIMAX_DMEM_MMIO_EN
      gpio_in = 32'hCAFE_F00D;
`endif
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "reset");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "reset");
`ifdef MINIMAX_DMEM_MMIO_EN
      chk("reset gpio_out1", gpio_out1, 32'h0);
      chk("reset gpio_out3", gpio_out3, 32'h0);
`endif
      reset = 1'b0;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "idle");

      // Full-word store and load
      wr(BASE + 32'h8, 4'hF, 32'hDEAD_BEEF, "store");
      rd(BASE + 32'h8, 4'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "load");

      // Byte lanes
      wr(BASE + 32'h10, 4'hF, 32'h0000_0000, "lane_clr");
      wr(BASE + 32'h10, 4'b0100, 32'h00AB_0000, "lane_wr");
      rd(BASE + 32'h10, 4'h0, 32'h0, 32'h00AB_0000, 32'h00AB_0000, "lane_rd");
      wr(BASE + 32'h14, 4'hF, 32'h1122_3344, "lane2_pre");
      wr(BASE + 32'h17, 4'b1001, 32'hFFAB_CDEE, "lane2_wr");
      rd(BASE + 32'h14, 4'h0, 32'h0, 32'hFF22_33EE, 32'hFF22_33EE, "lane2_rd");

      // Same-edge store and load to one word
      wr(BASE + 32'h18, 4'hF, 32'h0BAD_0BAD, "coll_pre");
      rd(BASE + 32'h18, 4'hF, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, "coll");

      // Misses: below base and one past the top of the window
      rd(BASE - 32'h4, 4'h0, 32'h0, 32'h0, 32'h0, "miss_rd");
      wr(BASE + 32'hFFC, 4'hF, 32'h0A0A_0A0A, "top_pre");
      wr(BASE, 4'hF, 32'h55AA_AA55, "bot_pre");
      wr(BASE - 32'h4, 4'hF, 32'hFFFF_FFFF, "miss_wr_lo");
      wr(BASE + 32'h1000, 4'hF, 32'hFFFF_FFFF, "miss_wr_hi");
      rd(BASE + 32'hFFC, 4'h0, 32'h0, 32'h0A0A_0A0A, 32'h0A0A_0A0A, "top_rd");
      rd(BASE, 4'h0, 32'h0, 32'h55AA_AA55, 32'h55AA_AA55, "bot_rd");

      // Back-to-back: latency-1 accepts in ACK, latency-3 ignores it in WAIT
      addr = BASE + 32'h8;
      rreq = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "b2b");
      cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, "b2b");
      addr = BASE + 32'h10;
      rreq = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "b2b");
      cyc(1'b1, 32'h00AB_0000, 1'b1, 32'hDEAD_BEEF, "b2b");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "b2b");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "b2b");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "b2b");

      // Reset one cycle after rreq aborts the read
      addr = BASE + 32'h8;
      rreq = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "abort");
      reset = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, "abort");
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 32'h0, 1'b0, 32'h0, "abort");
      end
      rd(BASE + 32'h8, 4'h0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "abort_keep");

`ifdef MINIMAX_DMEM_MMIO_EN
      wr(MMIO, 4'hF, 32'h0000_00A5, "mmio_wr");
      chk("mmio gpio_out1", gpio_out1, 32'h0000_00A5);
      chk("mmio gpio_out3", gpio_out3, 32'h0000_00A5);
      rd(MMIO + 32'h4, 4'h0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, "mmio_in");
      rd(MMIO, 4'h0, 32'h0, 32'h0000_00A5, 32'h0000_00A5, "mmio_out");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
